// File: rtl/lmt_update_seq.sv
// lmt_update_seq
//   Commits a fresh timestamp into the protected Last-Modification-Time (LMT)
//   region each time the attestation monitor raises upLMT. A free-running
//   counter is snapshotted on the request and written out as little-endian
//   16-bit words through a request/grant write port shared with the CPU bus.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   reset     : synchronous active-high reset, overrides every other input
//   upLMT     : update request level, acted on at its rising edge
//   mem_gnt   : write port grant from the bus arbiter
//   mem_req   : write port request (high in REQ)
//   mem_addr  : write byte address, LMT_BASE + 2*word index
//   mem_din   : write data, snapshot word selected by the word index
//   mem_wen   : write strobe, mem_req & mem_gnt
//   ts        : free-running timestamp counter
//   busy      : high whenever a commit is in progress
//   done      : one-cycle pulse after the last word is written
//   timeout   : one-cycle pulse when a commit is abandoned for lack of grant
module lmt_update_seq #(
  parameter logic [15:0] LMT_BASE  = 16'h0040,
  parameter int unsigned LMT_WORDS = 4,
  parameter int unsigned TS_WIDTH  = 64,
  parameter logic [15:0] WAIT_MAX  = 16'h00FF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                upLMT,
  input  logic                mem_gnt,
  output logic                mem_req,
  output logic [15:0]         mem_addr,
  output logic [15:0]         mem_din,
  output logic                mem_wen,
  output logic [TS_WIDTH-1:0] ts,
  output logic                busy,
  output logic                done,
  output logic                timeout
);

  localparam int unsigned IDX_W = (LMT_WORDS > 1) ? $clog2(LMT_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LMT_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE,
    ST_ABORT
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [TS_WIDTH-1:0] snap;
  logic [IDX_W-1:0]    idx;
  logic [15:0]         wait_cnt;
  logic                pend;
  logic                up_q;
  logic                rise;
  logic                start;
  logic                last_word;

  assign rise      = upLMT & ~up_q;
  assign last_word = (idx == LAST_IDX);

  // Address and data are pure functions of idx/snap, so they stay stable
  // through a stalled grant and fall back to LMT_BASE / 0 under reset.
  assign mem_addr = LMT_BASE + (16'(idx) << 1);
  assign mem_din  = snap[16*idx +: 16];
  assign mem_wen  = mem_req & mem_gnt;
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_next = state;
    start      = 1'b0;
    mem_req    = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    case (state)
      ST_IDLE: begin
        // A held-over request and a new rise in the same cycle start one commit.
        if (rise || pend) begin
          start      = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          if (last_word) state_next = ST_DONE;
        end else if (wait_cnt == WAIT_MAX - 16'd1) begin
          state_next = ST_ABORT;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      ST_ABORT: begin
        timeout    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ts       <= '0;
      snap     <= '0;
      idx      <= '0;
      wait_cnt <= '0;
      pend     <= 1'b0;
      up_q     <= 1'b0;
    end else begin
      state <= state_next;
      up_q  <= upLMT;
      ts    <= ts + TS_WIDTH'(1);

      if (start) begin
        snap     <= ts;
        idx      <= '0;
        wait_cnt <= '0;
      end else if (state == ST_REQ) begin
        if (mem_gnt) begin
          wait_cnt <= '0;
          if (!last_word) idx <= idx + IDX_W'(1);
        end else begin
          wait_cnt <= wait_cnt + 16'd1;
        end
      end

      if (start) pend <= 1'b0;
      else if (rise && state != ST_IDLE) pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lmt_update_seq.sv
// tb_lmt_update_seq
//   Directed bench for lmt_update_seq. dut runs with default parameters;
//   dut_b uses WAIT_MAX=4 with its grant tied low for the abort scenario.
//   Inputs are driven on the falling edge, outputs sampled #1 after that.
module tb_lmt_update_seq;

  logic        clk;
  logic        reset;
  logic        upLMT;
  logic        mem_gnt;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_wen;
  logic [63:0] ts;
  logic        busy;
  logic        done;
  logic        timeout;

  logic        up_b;
  logic        gnt_b;
  logic        req_b;
  logic [15:0] addr_b;
  logic [15:0] din_b;
  logic        wen_b;
  logic [63:0] ts_b;
  logic        busy_b;
  logic        done_b;
  logic        timeout_b;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [63:0] ts_m;
  logic [63:0] snap_e;
  logic [63:0] snap_b;

  lmt_update_seq dut (
    .clk(clk), .reset(reset), .upLMT(upLMT), .mem_gnt(mem_gnt),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_wen(mem_wen), .ts(ts), .busy(busy), .done(done), .timeout(timeout)
  );

  lmt_update_seq #(.WAIT_MAX(16'd4)) dut_b (
    .clk(clk), .reset(reset), .upLMT(up_b), .mem_gnt(gnt_b),
    .mem_req(req_b), .mem_addr(addr_b), .mem_din(din_b),
    .mem_wen(wen_b), .ts(ts_b), .busy(busy_b), .done(done_b),
    .timeout(timeout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the counter model follows reset/increment rules.
  task automatic step();
    @(posedge clk);
    if (reset) ts_m = '0;
    else ts_m = ts_m + 64'd1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    upLMT = 1'b0;
    up_b  = 1'b0;
    step();
    step();
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tmo", timeout, 0);
    chk("rst_addr", mem_addr, 16'h0040);
    chk("rst_din", mem_din, 0);
    chk("rst_ts", ts, 0);
    chk("rst_b_busy", busy_b, 0);
    chk("rst_b_req", req_b, 0);
    reset = 1'b0;
  endtask

  // Called in the first REQ cycle. Walks every word, optionally stalling
  // stall_len cycles on stall_word, then checks the DONE pulse and return
  // to IDLE. up_pat supplies upLMT per cycle of the commit.
  task automatic commit(input logic [63:0] snap, input int unsigned stall_word,
                        input int unsigned stall_len, input logic [15:0] up_pat);
    int unsigned k = 0;
    for (int unsigned w = 0; w < 4; w++) begin
      int unsigned n_cyc = (w == stall_word) ? stall_len + 1 : 1;
      for (int unsigned s = 0; s < n_cyc; s++) begin
        mem_gnt = (s == n_cyc - 1);
        upLMT   = up_pat[k];
        k++;
        #1;
        chk("req", mem_req, 1);
        chk("addr", mem_addr, 16'h0040 + 16'(2 * w));
        chk("din", mem_din, snap[16*w +: 16]);
        chk("wen", mem_wen, mem_gnt);
        chk("busy", busy, 1);
        chk("done_early", done, 0);
        chk("tmo", timeout, 0);
        chk("ts", ts, ts_m);
        step();
      end
    end
    upLMT = up_pat[k];
    #1;
    chk("done", done, 1);
    chk("done_req", mem_req, 0);
    chk("done_wen", mem_wen, 0);
    chk("done_busy", busy, 1);
    chk("done_tmo", timeout, 0);
    step();
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
  endtask

  initial begin
    reset   = 1'b1;
    upLMT   = 1'b0;
    mem_gnt = 1'b1;
    up_b    = 1'b0;
    gnt_b   = 1'b0;
    ts_m    = '0;
    snap_e  = '0;
    snap_b  = '0;
    @(negedge clk);

    // Basic commit with the rise sampled at ts = 0x10.
    do_reset();
    for (int i = 0; i < 16; i++) step();
    #1;
    chk("ts_0x10", ts, 64'h10);
    upLMT  = 1'b1;
    snap_e = 64'h10;
    step();
    commit(snap_e, 99, 0, 16'h0000);

    // Same, with three ungranted cycles on word 2.
    do_reset();
    for (int i = 0; i < 16; i++) step();
    upLMT = 1'b1;
    step();
    commit(64'h10, 2, 3, 16'h0000);

    // No grant at all on the WAIT_MAX=4 instance.
    do_reset();
    up_b   = 1'b1;
    snap_b = ts_m;
    step();
    up_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("b_req", req_b, 1);
      chk("b_addr", addr_b, 16'h0040);
      chk("b_din", din_b, snap_b[15:0]);
      chk("b_wen", wen_b, 0);
      chk("b_busy", busy_b, 1);
      chk("b_tmo_early", timeout_b, 0);
      chk("b_ts", ts_b, ts_m);
      step();
    end
    #1;
    chk("b_tmo", timeout_b, 1);
    chk("b_tmo_req", req_b, 0);
    chk("b_tmo_busy", busy_b, 1);
    chk("b_done", done_b, 0);
    step();
    #1;
    chk("b_idle_busy", busy_b, 0);
    chk("b_idle_tmo", timeout_b, 0);

    // Two extra rises during a commit merge into exactly one follow-up commit.
    for (int i = 0; i < 3; i++) step();
    upLMT  = 1'b1;
    snap_e = ts_m;
    step();
    commit(snap_e, 99, 0, 16'b01010);
    snap_e = ts_m;
    step();
    commit(snap_e, 99, 0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      chk("no_third", busy, 0);
    end

    // Reset in the cycle of the second write abandons the commit.
    upLMT = 1'b1;
    step();
    upLMT = 1'b0;
    #1;
    chk("r_w0_addr", mem_addr, 16'h0040);
    step();
    #1;
    chk("r_w1_addr", mem_addr, 16'h0042);
    chk("r_w1_wen", mem_wen, 1);
    reset = 1'b1;
    step();
    #1;
    chk("r_req", mem_req, 0);
    chk("r_ts", ts, 0);
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk("r_addr", mem_addr, 16'h0040);
    chk("r_din", mem_din, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      chk("r_no_done", done, 0);
    end
    upLMT  = 1'b1;
    snap_e = ts_m;
    step();
    commit(snap_e, 99, 0, 16'h0000);

    // Counter wrap: preload two counts below all-ones.
    step();
    force dut.ts = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.ts;
    ts_m  = 64'hFFFF_FFFF_FFFF_FFFE;
    upLMT = 1'b1;
    step();
    commit(64'hFFFF_FFFF_FFFF_FFFE, 99, 0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lmt_update_seq.md
# lmt_update_seq

Sequencer that commits a fresh timestamp into the protected Last-Modification-Time (LMT) region whenever the attestation monitor raises `upLMT`. It owns a free-running 64-bit timestamp counter, snapshots it on each `upLMT` rising edge, and writes the snapshot as 16-bit words to the LMT region over a request/grant memory write port. The write port is shared with the CPU bus. The block sits beside the RATA monitor and drives the only sanctioned writer of the LMT region.

## Interface
Parameters:
- `LMT_BASE`, 16'h0040: byte address of LMT word 0; must be word-aligned.
- `LMT_WORDS`, 4: number of 16-bit words written; must equal `TS_WIDTH/16`.
- `TS_WIDTH`, 64: timestamp counter width.
- `WAIT_MAX`, 16'h00FF: consecutive ungranted request cycles tolerated before abort; must be ≥1.

Ports:
- `clk` in 1: single clock; all state is updated on the rising edge.
- `reset` in 1: synchronous, active-high; has priority over all other inputs.
- `upLMT` in 1: update request from the monitor; level signal, acted on at its rising edge.
- `mem_gnt` in 1: write port grant from the bus arbiter.
- `mem_req` out 1: write port request.
- `mem_addr` out 16: write byte address.
- `mem_din` out 16: write data.
- `mem_wen` out 1: write strobe, defined as `mem_req & mem_gnt` (combinational).
- `ts` out TS_WIDTH: current counter value.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse on a completed commit.
- `timeout` out 1: one-cycle pulse on an aborted commit.

## Operation
- Counter `ts`:
  - Increments by 1 every cycle and wraps from all-ones to 0.
  - Reset value 0.
  - Never stalls.
- Edge detect: register `up_q` holds the previous `upLMT`. A rise is `upLMT & ~up_q`. `up_q` resets to 0, so `upLMT` high during the first cycle after reset counts as a rise.
- States: IDLE, REQ, DONE, ABORT.
  - IDLE → REQ on a rise. In the same edge: `snap <= ts` (the pre-increment value in the rise cycle), `idx <= 0`, `wait_cnt <= 0`.
  - REQ: `mem_req=1`, `mem_addr = LMT_BASE + 2*idx`, `mem_din = snap[16*idx+15 : 16*idx]` (little-endian, word 0 holds the LSBs). Address and data are held stable until granted.
    - With `mem_gnt=1`: the word is written this cycle and `wait_cnt <= 0`. If `idx == LMT_WORDS-1`, go to DONE; otherwise `idx <= idx+1`.
    - With `mem_gnt=0`: if `wait_cnt == WAIT_MAX-1`, go to ABORT; otherwise `wait_cnt <= wait_cnt+1`.
  - DONE: `done=1`, `mem_req=0`. Next state is IDLE.
  - ABORT: `timeout=1`, `mem_req=0`. Next state is IDLE. Words already written are not rolled back.
- Pending:
  - A rise seen in REQ, DONE or ABORT sets `pend`. Further rises while `pend` is set are merged into it.
  - In IDLE, if `pend` is set, the block starts exactly as on a rise and clears `pend`. The new snapshot is `ts` in that IDLE cycle.
  - A rise in IDLE while `pend` is set starts one commit only.
- Reset values:
  - State IDLE.
  - `mem_req`, `done`, `timeout`, `busy`, `pend`, `up_q` all 0.
  - `mem_addr` = LMT_BASE, `mem_din` = 0.
  - `ts` = 0, `snap` = 0.
- Reset asserted mid-commit abandons the commit. No `done` or `timeout` pulse is produced, and outputs are reset values on the next cycle.

## Timing
- Rise sampled in cycle n. With `mem_gnt` held at 1:
  - `mem_wen` is high in cycles n+1 through n+LMT_WORDS.
  - `done` is high in cycle n+LMT_WORDS+1.
  - IDLE is reached in cycle n+LMT_WORDS+2.
  - Earliest next start is n+LMT_WORDS+2, so one commit takes 6 cycles at defaults.
- A grant delay of k cycles on any word extends the commit by k cycles.
- With no grant ever, `mem_req` stays high for WAIT_MAX cycles per word, then ABORT in the next cycle.
- `mem_wen` is never high outside REQ.
- `busy` rises in cycle n+1 and falls in the cycle where state returns to IDLE.

## Test plan
- Reset, then `upLMT` rises at `ts`=0x10 with `mem_gnt`=1 → writes (0x0040,0x0010), (0x0042,0), (0x0044,0), (0x0046,0) on consecutive cycles; `done` pulses once, 5 cycles after the rise.
- Same stimulus, but `mem_gnt` held low 3 cycles on word 2 → address 0x0044 and its data held through the stall; `done` arrives 3 cycles later; no `timeout`.
- `mem_gnt` stuck at 0, WAIT_MAX=4 → `mem_req` high 4 cycles at 0x0040, `timeout` pulses in the 5th cycle, no `mem_wen`, `busy` drops next cycle.
- Two additional `upLMT` rises during an active commit → exactly one extra commit follows. Its snapshot equals `ts` in the IDLE cycle after `done`, and it carries 64-bit data distinct from the first.
- `reset` asserted in the cycle of the second write → next cycle `mem_req`=0, `ts`=0, `busy`=0; no `done`; a later rise writes a fresh snapshot starting from word 0.
- Preload the counter near wrap (0xFFFF_FFFF_FFFF_FFFE at the rise) → words written are 0xFFFE, 0xFFFF, 0xFFFF, 0xFFFF; `ts` reads 0 two cycles after the rise.
